// File: rtl/rom_spi_reader_pkg.sv
// Shared constants and address helper for the SPI NOR ROM page reader.
package rom_spi_reader_pkg;

  localparam logic [7:0] SPI_CMD_READ    = 8'h03;
  localparam int         FLASH_ADDR_BITS = 24;

  typedef logic [FLASH_ADDR_BITS-1:0] flash_addr_t;

  // Page bits shifted beyond the flash address width are discarded; the sum wraps.
  function automatic flash_addr_t page_base_addr(input logic [15:0] page,
                                                 input flash_addr_t base,
                                                 input int          page_bits);
    flash_addr_t offset;
    offset = flash_addr_t'(page) << page_bits;
    return base + offset;
  endfunction

endpackage

// File: rtl/rom_spi_reader_shift.sv
// SPI mode-0 shift engine: clock divider, SCK, 32-bit TX shifter, 8-bit RX shifter.
module spi_shift_engine #(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        load_tx,
  input  logic [5:0]  nbits,
  input  logic [31:0] tx_data,
  input  logic        miso,
  output logic        sck,
  output logic        mosi,
  output logic        done,
  output logic [7:0]  rx
);

  localparam int             DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic             run_q, run_d;
  logic             sck_q, sck_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [5:0]       bits_q, bits_d;
  logic [31:0]      tx_q, tx_d;
  logic [7:0]       rx_q, rx_d;
  logic             tick;

  assign tick = run_q && (div_q == DIV_LAST);
  // done marks the edge that produces the last falling SCK of the burst.
  assign done = tick && sck_q && (bits_q == 6'd1);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path infers a latch.
    run_d  = run_q;
    sck_d  = sck_q;
    div_d  = div_q;
    bits_d = bits_q;
    tx_d   = tx_q;
    rx_d   = rx_q;
    if (run_q) div_d = tick ? '0 : div_q + 1'b1;
    if (tick) begin
      sck_d = ~sck_q;
      if (!sck_q) begin
        rx_d = {rx_q[6:0], miso};
      end else begin
        bits_d = bits_q - 6'd1;
        tx_d   = {tx_q[30:0], 1'b0};
        if (bits_q == 6'd1) run_d = 1'b0;
      end
    end
    if (load_tx) tx_d = tx_data;
    if (start) begin
      run_d  = 1'b1;
      bits_d = nbits;
      div_d  = '0;
    end
  end

  // NOTE: state flops use non-blocking assignments and clear asynchronously on rst_n low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= 1'b0;
      sck_q  <= 1'b0;
      div_q  <= '0;
      bits_q <= '0;
      tx_q   <= '0;
      rx_q   <= '0;
    end else begin
      run_q  <= run_d;
      sck_q  <= sck_d;
      div_q  <= div_d;
      bits_q <= bits_d;
      tx_q   <= tx_d;
      rx_q   <= rx_d;
    end
  end

  assign sck  = sck_q;
  assign mosi = tx_q[31];
  assign rx   = rx_q;

endmodule

// File: rtl/rom_spi_reader.sv
// ROM page responder: streams one MEM_PAGE-byte page from SPI NOR flash per request.
module rom_spi_reader
  import rom_spi_reader_pkg::*;
#(
  parameter int          MEM_PAGE   = 32,
  parameter flash_addr_t FLASH_BASE = 24'h000000,
  parameter int          CLK_DIV    = 2,
  parameter int          CS_GAP     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rom_start,
  input  logic [15:0] rom_page,
  output logic        rom_busy,
  output logic        rom_ready,
  output logic [7:0]  rom_data,
  output logic        spi_sck,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam int          PAGE_BITS  = $clog2(MEM_PAGE);
  localparam logic [7:0]  COUNT_INIT = 8'(MEM_PAGE - 1);
  // The IDLE cycle that takes the next request also keeps cs_n high, so GAP is one shorter.
  localparam logic [15:0] GAP_LAST   = (CS_GAP > 1) ? 16'(CS_GAP - 2) : 16'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_DATA,
    S_STROBE,
    S_GAP
  } state_e;

  state_e      state_q, state_d;
  logic        busy_q, busy_d;
  logic        ready_q, ready_d;
  logic [7:0]  data_q, data_d;
  logic        cs_n_q, cs_n_d;
  logic [7:0]  count_q, count_d;
  logic [15:0] gap_q, gap_d;

  logic        eng_start;
  logic        eng_load;
  logic [5:0]  eng_nbits;
  logic [31:0] eng_tx;
  logic        eng_done;
  logic [7:0]  eng_rx;

  assign eng_tx = {SPI_CMD_READ, page_base_addr(rom_page, FLASH_BASE, PAGE_BITS)};

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    ready_d   = 1'b0;
    data_d    = data_q;
    cs_n_d    = cs_n_q;
    count_d   = count_q;
    gap_d     = gap_q;
    eng_start = 1'b0;
    eng_load  = 1'b0;
    eng_nbits = 6'd8;
    unique case (state_q)
      S_IDLE: begin
        if (rom_start) begin
          busy_d    = 1'b1;
          cs_n_d    = 1'b0;
          count_d   = COUNT_INIT;
          eng_start = 1'b1;
          eng_load  = 1'b1;
          eng_nbits = 6'd32;
          state_d   = S_CMD;
        end
      end
      S_CMD: begin
        if (eng_done) begin
          eng_start = 1'b1;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (eng_done) begin
          ready_d = 1'b1;
          data_d  = eng_rx;
          state_d = S_STROBE;
        end
      end
      S_STROBE: begin
        if (count_q != 8'd0) begin
          count_d   = count_q - 8'd1;
          eng_start = 1'b1;
          state_d   = S_DATA;
        end else begin
          // Busy and cs_n release on the same edge that ends the final strobe.
          busy_d  = 1'b0;
          cs_n_d  = 1'b1;
          gap_d   = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        gap_d = gap_q + 16'd1;
        if (gap_q == GAP_LAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      data_q  <= 8'h00;
      cs_n_q  <= 1'b1;
      count_q <= 8'h00;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      data_q  <= data_d;
      cs_n_q  <= cs_n_d;
      count_q <= count_d;
      gap_q   <= gap_d;
    end
  end

  spi_shift_engine #(
    .CLK_DIV (CLK_DIV)
  ) u_shift (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (eng_start),
    .load_tx (eng_load),
    .nbits   (eng_nbits),
    .tx_data (eng_tx),
    .miso    (spi_miso),
    .sck     (spi_sck),
    .mosi    (spi_mosi),
    .done    (eng_done),
    .rx      (eng_rx)
  );

  assign rom_busy  = busy_q;
  assign rom_ready = ready_q;
  assign rom_data  = data_q;
  assign spi_cs_n  = cs_n_q;

endmodule

// File: tb/tb_rom_spi_reader.sv
// Directed bench for rom_spi_reader with a READ-0x03 flash model: byte(a) = a[7:0] ^ 8'hA5.
module tb_rom_spi_reader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Instance A: FLASH_BASE 0. Instance B: FLASH_BASE near the top of flash.
  logic        rom_start_a = 1'b0, rom_start_b = 1'b0;
  logic [15:0] rom_page_a = '0, rom_page_b = '0;
  logic        rom_busy_a, rom_ready_a, spi_sck_a, spi_cs_n_a, spi_mosi_a;
  logic        rom_busy_b, rom_ready_b, spi_sck_b, spi_cs_n_b, spi_mosi_b;
  logic [7:0]  rom_data_a, rom_data_b;
  logic        spi_miso_a = 1'b0, spi_miso_b = 1'b0;

  rom_spi_reader #(.MEM_PAGE(32), .FLASH_BASE(24'h000000), .CLK_DIV(2), .CS_GAP(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .rom_start(rom_start_a), .rom_page(rom_page_a),
    .rom_busy(rom_busy_a), .rom_ready(rom_ready_a), .rom_data(rom_data_a),
    .spi_sck(spi_sck_a), .spi_cs_n(spi_cs_n_a), .spi_mosi(spi_mosi_a), .spi_miso(spi_miso_a)
  );

  rom_spi_reader #(.MEM_PAGE(32), .FLASH_BASE(24'hFFFFE0), .CLK_DIV(2), .CS_GAP(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .rom_start(rom_start_b), .rom_page(rom_page_b),
    .rom_busy(rom_busy_b), .rom_ready(rom_ready_b), .rom_data(rom_data_b),
    .spi_sck(spi_sck_b), .spi_cs_n(spi_cs_n_b), .spi_mosi(spi_mosi_b), .spi_miso(spi_miso_b)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic flash_bit(input logic [23:0] addr, input int idx);
    logic [23:0] a;
    logic [7:0]  b;
    a = addr + 24'(idx / 8);
    b = a[7:0] ^ 8'hA5;
    return b[7 - (idx % 8)];
  endfunction

  // Flash models: capture 32 command bits on SCK rise, drive data after each fall.
  int          fl_cnt_a = 0, fl_cnt_b = 0;
  logic [31:0] fl_sh_a = '0, fl_sh_b = '0;
  logic [31:0] cmds_a[$];
  logic [31:0] cmds_b[$];

  always @(posedge spi_sck_a or posedge spi_cs_n_a) begin
    if (spi_cs_n_a) fl_cnt_a = 0;
    else begin
      if (fl_cnt_a < 32) begin
        fl_sh_a = {fl_sh_a[30:0], spi_mosi_a};
        if (fl_cnt_a == 31) cmds_a.push_back(fl_sh_a);
      end
      fl_cnt_a++;
    end
  end
  always @(negedge spi_sck_a)
    if (spi_cs_n_a === 1'b0 && fl_cnt_a >= 32) spi_miso_a <= flash_bit(fl_sh_a[23:0], fl_cnt_a - 32);

  always @(posedge spi_sck_b or posedge spi_cs_n_b) begin
    if (spi_cs_n_b) fl_cnt_b = 0;
    else begin
      if (fl_cnt_b < 32) begin
        fl_sh_b = {fl_sh_b[30:0], spi_mosi_b};
        if (fl_cnt_b == 31) cmds_b.push_back(fl_sh_b);
      end
      fl_cnt_b++;
    end
  end
  always @(negedge spi_sck_b)
    if (spi_cs_n_b === 1'b0 && fl_cnt_b >= 32) spi_miso_b <= flash_bit(fl_sh_b[23:0], fl_cnt_b - 32);

  // Port monitor, sampled on the falling clock edge.
  logic [7:0] strobe_a[$];
  int         strobe_cyc_a[$];
  logic       busy_after_a[$];
  int         cs_runs_a[$];
  logic [7:0] strobe_b[$];
  int         cs_run_a = 0;
  int         double_ready_a = 0;
  logic       ready_prev_a = 1'b0;

  always @(negedge clk) begin
    if (rom_ready_a === 1'b1) begin
      strobe_a.push_back(rom_data_a);
      strobe_cyc_a.push_back(cyc);
    end
    if (ready_prev_a) busy_after_a.push_back(rom_busy_a);
    if (rom_ready_a === 1'b1 && ready_prev_a) double_ready_a++;
    ready_prev_a = (rom_ready_a === 1'b1);
    if (spi_cs_n_a !== 1'b0) cs_run_a++;
    else begin
      if (cs_run_a > 0) cs_runs_a.push_back(cs_run_a);
      cs_run_a = 0;
    end
    if (rom_ready_b === 1'b1) strobe_b.push_back(rom_data_b);
  end

  task automatic clear_a();
    strobe_a.delete();
    strobe_cyc_a.delete();
    busy_after_a.delete();
    cs_runs_a.delete();
    cmds_a.delete();
  endtask

  task automatic wait_strobes_a(input int n, input string tag);
    int k = 0;
    while (strobe_a.size() < n && k < 2000) begin
      @(negedge clk); #1;
      k++;
    end
    check({tag, "_strobe_arrived"}, 32'(strobe_a.size() >= n), 32'd1);
  endtask

  task automatic wait_idle_a(input string tag);
    int k = 0;
    while (rom_busy_a !== 1'b0 && k < 2000) begin
      @(negedge clk); #1;
      k++;
    end
    check({tag, "_idle"}, 32'(rom_busy_a), 32'd0);
  endtask

  task automatic check_page_a(input logic [23:0] addr, input int first, input string tag);
    logic [23:0] ai;
    for (int i = 0; i < 32 && first + i < strobe_a.size(); i++) begin
      ai = addr + 24'(i);
      check($sformatf("%s_data%0d", tag, i), 32'(strobe_a[first + i]), 32'(ai[7:0] ^ 8'hA5));
      if (i > 0)
        check($sformatf("%s_gap%0d", tag, i),
              32'(strobe_cyc_a[first + i] - strobe_cyc_a[first + i - 1]), 32'd33);
      if (first + i < busy_after_a.size())
        check($sformatf("%s_busy_after%0d", tag, i), 32'(busy_after_a[first + i]),
              (i == 31) ? 32'd0 : 32'd1);
    end
  endtask

  int t0;

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", 32'(rom_busy_a), 32'd0);
    check("rst_ready", 32'(rom_ready_a), 32'd0);
    check("rst_data", 32'(rom_data_a), 32'd0);
    check("rst_cs_n", 32'(spi_cs_n_a), 32'd1);
    check("rst_sck", 32'(spi_sck_a), 32'd0);
    check("rst_mosi", 32'(spi_mosi_a), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;

    // Single page 3: latency counts the accepting IDLE cycle through the strobe cycle.
    clear_a();
    rom_page_a = 16'h0003; rom_start_a = 1'b1; t0 = cyc;
    wait_strobes_a(1, "p3");
    rom_start_a = 1'b0;
    wait_idle_a("p3");
    check("p3_latency", 32'((strobe_cyc_a.size() > 0 ? strobe_cyc_a[0] : t0) - t0 + 1), 32'd162);
    check("p3_count", 32'(strobe_a.size()), 32'd32);
    check("p3_cmd", (cmds_a.size() > 0) ? cmds_a[0] : 32'hDEADBEEF, 32'h03000060);
    check_page_a(24'h000060, 0, "p3");

    // rom_start held across two pages.
    repeat (10) @(negedge clk); #1;
    clear_a();
    rom_page_a = 16'h0003; rom_start_a = 1'b1;
    wait_strobes_a(1, "b2b1");
    rom_page_a = 16'h0004;
    wait_strobes_a(33, "b2b2");
    rom_start_a = 1'b0;
    wait_idle_a("b2b");
    check("b2b_count", 32'(strobe_a.size()), 32'd64);
    check("b2b_cmd0", (cmds_a.size() > 0) ? cmds_a[0] : 32'hDEADBEEF, 32'h03000060);
    check("b2b_cmd1", (cmds_a.size() > 1) ? cmds_a[1] : 32'hDEADBEEF, 32'h03000080);
    check("b2b_cs_gap", (cs_runs_a.size() > 1) ? 32'(cs_runs_a[1]) : 32'hFFFFFFFF, 32'd4);
    check_page_a(24'h000060, 0, "b2b_a");
    check_page_a(24'h000080, 32, "b2b_b");

    // Page changes and start re-pulses while busy are ignored.
    repeat (10) @(negedge clk); #1;
    clear_a();
    rom_page_a = 16'h0006; rom_start_a = 1'b1;
    wait_strobes_a(1, "ign");
    rom_start_a = 1'b0; rom_page_a = 16'h0009;
    wait_strobes_a(5, "ign5");
    rom_start_a = 1'b1; rom_page_a = 16'h000A;
    repeat (40) @(negedge clk);
    #1;
    rom_start_a = 1'b0; rom_page_a = 16'h000B;
    wait_idle_a("ign");
    check("ign_count", 32'(strobe_a.size()), 32'd32);
    check("ign_cmd", (cmds_a.size() > 0) ? cmds_a[0] : 32'hDEADBEEF, 32'h030000C0);
    check_page_a(24'h0000C0, 0, "ign");
    repeat (20) @(negedge clk); #1;
    check("ign_no_restart_cmds", 32'(cmds_a.size()), 32'd1);
    check("ign_no_restart_cs", 32'(spi_cs_n_a), 32'd1);

    // Asynchronous reset while shifting byte 10.
    clear_a();
    rom_page_a = 16'h0005; rom_start_a = 1'b1;
    wait_strobes_a(1, "rst");
    rom_start_a = 1'b0;
    wait_strobes_a(10, "rst10");
    for (int k = 0; k < 20 && spi_sck_a !== 1'b1; k++) begin
      @(negedge clk); #1;
    end
    check("rst_mid_sck_was_high", 32'(spi_sck_a), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 32'(rom_busy_a), 32'd0);
    check("rst_mid_ready", 32'(rom_ready_a), 32'd0);
    check("rst_mid_cs_n", 32'(spi_cs_n_a), 32'd1);
    check("rst_mid_sck", 32'(spi_sck_a), 32'd0);
    check("rst_mid_data", 32'(rom_data_a), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;

    // Fresh request after reset restarts from the command phase.
    clear_a();
    rom_page_a = 16'h0007; rom_start_a = 1'b1; t0 = cyc;
    wait_strobes_a(1, "post");
    rom_start_a = 1'b0;
    wait_idle_a("post");
    check("post_latency", 32'((strobe_cyc_a.size() > 0 ? strobe_cyc_a[0] : t0) - t0 + 1), 32'd162);
    check("post_count", 32'(strobe_a.size()), 32'd32);
    check("post_cmd", (cmds_a.size() > 0) ? cmds_a[0] : 32'hDEADBEEF, 32'h030000E0);
    check_page_a(24'h0000E0, 0, "post");

    // Base FFFFE0 + page 1 wraps to flash address 0.
    rom_page_b = 16'h0001; rom_start_b = 1'b1;
    for (int k = 0; k < 2000 && strobe_b.size() == 0; k++) begin
      @(negedge clk); #1;
    end
    rom_start_b = 1'b0;
    for (int k = 0; k < 2000 && rom_busy_b !== 1'b0; k++) begin
      @(negedge clk); #1;
    end
    check("wrap_idle", 32'(rom_busy_b), 32'd0);
    check("wrap_cmd", (cmds_b.size() > 0) ? cmds_b[0] : 32'hDEADBEEF, 32'h03000000);
    check("wrap_count", 32'(strobe_b.size()), 32'd32);
    check("wrap_data0", (strobe_b.size() > 0) ? 32'(strobe_b[0]) : 32'hFFFF, 32'hA5);
    check("wrap_data1", (strobe_b.size() > 1) ? 32'(strobe_b[1]) : 32'hFFFF, 32'hA4);
    check("wrap_data31", (strobe_b.size() > 31) ? 32'(strobe_b[31]) : 32'hFFFF, 32'hBA);

    check("ready_never_twice", 32'(double_ready_a), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
